// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - operand/opcode vector source for logical_alu (single load or exhaustive sweep)
// Optional feature macro: ALU_SEQ_CIN_SWEEP_EN (c_in becomes part of the sweep index)
module alu_operand_sequencer #(
  parameter int WIDTH = 4,
  parameter int OP_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [WIDTH-1:0]        sw_a,
  input  logic [WIDTH-1:0]        sw_b,
  input  logic [OP_W-1:0]         sw_op,
  input  logic                    sw_cin,
  input  logic                    ready,
  output logic [WIDTH-1:0]        a,
  output logic [WIDTH-1:0]        b,
  output logic                    c_in,
  output logic [OP_W-1:0]         Op,
  output logic                    valid,
  output logic                    busy,
  output logic                    done,
  output logic [2*WIDTH+OP_W+1:0] count
);

  localparam int CNT_W = 2*WIDTH + OP_W + 2;
`ifdef ALU_SEQ_CIN_SWEEP_EN
  localparam int IDX_W = 2*WIDTH + OP_W + 1;
`else
  localparam int IDX_W = 2*WIDTH + OP_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               valid_q, valid_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // The sweep index is the presented vector itself, so no separate counter is kept.
  logic [IDX_W-1:0]   idx_cur;
  logic [IDX_W-1:0]   idx_next;
  logic               idx_last;

  // View the current output registers as the sweep index and form its successor.
  always_comb begin
`ifdef ALU_SEQ_CIN_SWEEP_EN
    idx_cur = {a_q, b_q, cin_q, op_q};
`else
    idx_cur = {a_q, b_q, op_q};
`endif
    idx_next = idx_cur + {{(IDX_W-1){1'b0}}, 1'b1};
    idx_last = &idx_cur;
  end

  // Next-state, vector and counter logic for the IDLE -> LOAD -> ISSUE -> FIN sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    op_d    = op_q;
    valid_d = valid_q;
    mode_d  = mode_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          count_d = '0;
          state_d = S_LOAD;
          if (!mode) begin
            a_d   = sw_a;
            b_d   = sw_b;
            op_d  = sw_op;
            cin_d = sw_cin;
          end else begin
            a_d   = '0;
            b_d   = '0;
            op_d  = '0;
`ifdef ALU_SEQ_CIN_SWEEP_EN
            cin_d = 1'b0;
`else
            cin_d = sw_cin;
`endif
          end
        end
      end
      S_LOAD: begin
        valid_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (valid_q && ready) begin
          count_d = (&count_q) ? count_q : count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (!mode_q || idx_last) begin
            valid_d = 1'b0;
            state_d = S_FIN;
          end else begin
`ifdef ALU_SEQ_CIN_SWEEP_EN
            {a_d, b_d, cin_d, op_d} = idx_next;
`else
            {a_d, b_d, op_d} = idx_next;
`endif
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      op_q    <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign c_in  = cin_q;
  assign Op    = op_q;
  assign valid = valid_q;
  assign count = count_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_FIN);

endmodule
